// File: rtl/prog_dispatch.sv
// Program dispatcher: queues up to two {prog, arg1, arg2} requests and sequences
// each one through launch, run and completion by watching the processor's fetch address.
module prog_dispatch #(
  parameter int TIMEOUT  = 1024,
  parameter int MAX_PROG = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_prog,
  input  logic [31:0] req_arg1,
  input  logic [31:0] req_arg2,
  output logic        req_ready,
  input  logic [31:0] cpu_pc,
  output logic [31:0] sel_out,
  output logic [31:0] in1_out,
  output logic [31:0] in2_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, ERR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  logic [15:0] cnt_reg;

  logic [66:0] entry_reg [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;

  logic        push;
  logic        pop;
  logic [66:0] head;
  logic [2:0]  head_prog;
  logic        head_valid_id;
  logic        timeout_hit;

  assign req_ready     = (count_reg != 2'd2);
  assign push          = req_valid && req_ready;
  assign pop           = (state_reg == IDLE) && (count_reg != 2'd0);
  assign head          = entry_reg[rd_ptr_reg];
  assign head_prog     = head[66:64];
  assign head_valid_id = (head_prog != 3'd0) && (32'(head_prog) <= 32'(MAX_PROG));
  assign timeout_hit   = (cnt_reg == TMO_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr_reg] <= {req_prog, req_arg1, req_arg2};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A completion condition seen on the timeout cycle wins over the abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      sel_out   <= 32'd0;
      in1_out   <= 32'd0;
      in2_out   <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            if (head_valid_id) begin
              state_reg <= LAUNCH;
              cnt_reg   <= 16'd0;
              sel_out   <= {29'd0, head_prog};
              in1_out   <= head[63:32];
              in2_out   <= head[31:0];
              busy      <= 1'b1;
            end else begin
              state_reg <= ERR;
              sel_out   <= 32'd0;
              err       <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (cpu_pc != 32'd0) begin
            state_reg <= RUN;
            sel_out   <= 32'd0;
            cnt_reg   <= cnt_reg + 16'd1;
          end else if (timeout_hit) begin
            state_reg <= ERR;
            sel_out   <= 32'd0;
            busy      <= 1'b0;
            err       <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        RUN: begin
          if (cpu_pc == 32'd0) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else if (timeout_hit) begin
            state_reg <= ERR;
            sel_out   <= 32'd0;
            busy      <= 1'b0;
            err       <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        ERR: begin
          state_reg <= IDLE;
          err       <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_dispatch.sv
// Directed bench for prog_dispatch: one default-parameter instance plus a
// TIMEOUT=16 instance for the abort and coincident-completion scenarios.
module tb_prog_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0]  req_prog = 3'd0;
  logic [31:0] req_arg1 = 32'd0, req_arg2 = 32'd0;
  logic [31:0] a_pc = 32'd0, b_pc = 32'd0;

  logic        a_ready, a_busy, a_done, a_err;
  logic [31:0] a_sel, a_in1, a_in2;
  logic        b_ready, b_busy, b_done, b_err;
  logic [31:0] b_sel, b_in1, b_in2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prog_dispatch u_dut (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_prog(req_prog),
    .req_arg1(req_arg1), .req_arg2(req_arg2), .req_ready(a_ready), .cpu_pc(a_pc),
    .sel_out(a_sel), .in1_out(a_in1), .in2_out(a_in2),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  prog_dispatch #(.TIMEOUT(16), .MAX_PROG(5)) u_tmo (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_prog(req_prog),
    .req_arg1(req_arg1), .req_arg2(req_arg2), .req_ready(b_ready), .cpu_pc(b_pc),
    .sel_out(b_sel), .in1_out(b_in1), .in2_out(b_in2),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [2:0] p, input logic [31:0] x1, input logic [31:0] x2);
    a_valid = 1'b1; req_prog = p; req_arg1 = x1; req_arg2 = x2;
    step();
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [2:0] p, input logic [31:0] x1, input logic [31:0] x2);
    b_valid = 1'b1; req_prog = p; req_arg1 = x1; req_arg2 = x2;
    step();
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    tests++;
    if ({a_sel, a_in1, a_in2} !== 96'd0) begin
      fails++; $display("FAIL reset_regs: got sel=%0d in1=%0d in2=%0d expected 0", a_sel, a_in1, a_in2);
    end
    tests++;
    if ({a_busy, a_done, a_err} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got busy/done/err=%b expected 000", {a_busy, a_done, a_err});
    end
    reset = 1'b0;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b expected 1", a_ready);
    end
    $display("[TB] reset: ready=%b busy=%b", a_ready, a_busy);
  endtask

  task automatic test_basic();
    int done_cnt;
    push_a(3'd1, 32'd10, 32'd0);
    step();
    tests++;
    if (a_sel !== 32'd1 || a_in1 !== 32'd10 || a_busy !== 1'b1) begin
      fails++; $display("FAIL basic_launch: got sel=%0d in1=%0d busy=%b expected sel=1 in1=10 busy=1", a_sel, a_in1, a_busy);
    end
    step();
    a_pc = 32'd100;
    step();
    tests++;
    if (a_sel !== 32'd0 || a_busy !== 1'b1) begin
      fails++; $display("FAIL basic_run_sel: got sel=%0d busy=%b expected sel=0 busy=1", a_sel, a_busy);
    end
    done_cnt = 0;
    repeat (19) begin step(); if (a_done) done_cnt++; end
    a_pc = 32'd0;
    repeat (4) begin step(); if (a_done) done_cnt++; end
    tests++;
    if (done_cnt !== 1) begin
      fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
    tests++;
    if (a_busy !== 1'b0 || a_in1 !== 32'd10) begin
      fails++; $display("FAIL basic_after: got busy=%b in1=%0d expected busy=0 in1=10", a_busy, a_in1);
    end
    $display("[TB] basic: done_pulses=%0d busy=%b", done_cnt, a_busy);
  endtask

  task automatic test_back_to_back();
    push_a(3'd2, 32'd20, 32'd21);
    push_a(3'd3, 32'd30, 32'd31);
    a_valid = 1'b1; req_prog = 3'd1; req_arg1 = 32'd40; req_arg2 = 32'd41;
    step();
    a_valid = 1'b0;
    tests++;
    if (a_ready !== 1'b0 || a_sel !== 32'd2) begin
      fails++; $display("FAIL b2b_full: got ready=%b sel=%0d expected ready=0 sel=2", a_ready, a_sel);
    end
    a_pc = 32'd100;
    step();
    a_pc = 32'd0;
    step();
    tests++;
    if (a_done !== 1'b1) begin
      fails++; $display("FAIL b2b_done2: got %b expected 1", a_done);
    end
    step();
    tests++;
    if (a_busy !== 1'b0 || a_sel !== 32'd0 || a_in1 !== 32'd20) begin
      fails++; $display("FAIL b2b_gap: got busy=%b sel=%0d in1=%0d expected busy=0 sel=0 in1=20", a_busy, a_sel, a_in1);
    end
    step();
    tests++;
    if (a_sel !== 32'd3 || a_in1 !== 32'd30 || a_in2 !== 32'd31) begin
      fails++; $display("FAIL b2b_launch3: got sel=%0d in1=%0d in2=%0d expected 3/30/31", a_sel, a_in1, a_in2);
    end
    a_pc = 32'd100; step(); a_pc = 32'd0; step(); step(); step();
    tests++;
    if (a_sel !== 32'd1 || a_in1 !== 32'd40 || a_in2 !== 32'd41) begin
      fails++; $display("FAIL b2b_launch1: got sel=%0d in1=%0d in2=%0d expected 1/40/41", a_sel, a_in1, a_in2);
    end
    a_pc = 32'd100; step(); a_pc = 32'd0; step(); step();
    tests++;
    if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_end: got busy=%b ready=%b expected 0/1", a_busy, a_ready);
    end
    $display("[TB] back_to_back: busy=%b ready=%b", a_busy, a_ready);
  endtask

  task automatic test_invalid();
    int err_cnt, done_cnt, sel_bad;
    push_a(3'd0, 32'd90, 32'd91);
    push_a(3'd7, 32'd92, 32'd93);
    err_cnt = 0; done_cnt = 0; sel_bad = 0;
    if (a_err) err_cnt++;
    repeat (6) begin
      step();
      if (a_err) err_cnt++;
      if (a_done) done_cnt++;
      if (a_sel !== 32'd0) sel_bad++;
    end
    tests++;
    if (err_cnt !== 2) begin
      fails++; $display("FAIL invalid_err_count: got %0d expected 2", err_cnt);
    end
    tests++;
    if (done_cnt !== 0 || sel_bad !== 0) begin
      fails++; $display("FAIL invalid_side: got done=%0d sel_nonzero=%0d expected 0/0", done_cnt, sel_bad);
    end
    tests++;
    if (a_in1 !== 32'd40) begin
      fails++; $display("FAIL invalid_in1_hold: got %0d expected 40", a_in1);
    end
    $display("[TB] invalid: err_pulses=%0d done_pulses=%0d", err_cnt, done_cnt);
  endtask

  task automatic test_reset_mid();
    int bad;
    push_a(3'd5, 32'd60, 32'd61);
    a_valid = 1'b1; req_prog = 3'd2; req_arg1 = 32'd70; req_arg2 = 32'd71;
    a_pc = 32'd100;
    step();
    a_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({a_sel, a_in1, a_in2} !== 96'd0 || {a_busy, a_done, a_err} !== 3'b000) begin
      fails++; $display("FAIL rstmid_outputs: got sel=%0d in1=%0d in2=%0d flags=%b expected all 0",
                        a_sel, a_in1, a_in2, {a_busy, a_done, a_err});
    end
    step();
    reset = 1'b0;
    a_pc = 32'd0;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_ready: got %b expected 1", a_ready);
    end
    bad = 0;
    repeat (8) begin
      step();
      if (a_busy || a_done || a_err || a_sel !== 32'd0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL rstmid_no_launch: got %0d active cycles expected 0", bad);
    end
    $display("[TB] reset_mid: active_cycles=%0d", bad);
  endtask

  task automatic test_timeout();
    int first;
    push_b(3'd4, 32'd50, 32'd51);
    step();
    tests++;
    if (b_sel !== 32'd4 || b_busy !== 1'b1) begin
      fails++; $display("FAIL tmo_launch: got sel=%0d busy=%b expected 4/1", b_sel, b_busy);
    end
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (b_err && first < 0) begin
        first = k;
        tests++;
        if (b_sel !== 32'd0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
          fails++; $display("FAIL tmo_err_outputs: got sel=%0d busy=%b done=%b expected 0/0/0", b_sel, b_busy, b_done);
        end
      end
    end
    tests++;
    if (first !== 16) begin
      fails++; $display("FAIL tmo_latency: got %0d expected 16", first);
    end
    tests++;
    if (b_busy !== 1'b0 || b_err !== 1'b0) begin
      fails++; $display("FAIL tmo_idle: got busy=%b err=%b expected 0/0", b_busy, b_err);
    end
    $display("[TB] timeout: err_after=%0d cycles", first);
  endtask

  task automatic test_coincide();
    push_b(3'd1, 32'd80, 32'd81);
    step();
    b_pc = 32'd100;
    repeat (15) step();
    b_pc = 32'd0;
    step();
    tests++;
    if (b_done !== 1'b1 || b_err !== 1'b0) begin
      fails++; $display("FAIL coincide: got done=%b err=%b expected done=1 err=0", b_done, b_err);
    end
    step();
    tests++;
    if (b_busy !== 1'b0 || b_err !== 1'b0) begin
      fails++; $display("FAIL coincide_idle: got busy=%b err=%b expected 0/0", b_busy, b_err);
    end
    $display("[TB] coincide: done=%b err=%b", b_done, b_err);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    test_timeout();
    test_coincide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
